// File: rtl/mm_pkg.sv
// Package: mm_pkg
// Shared types and helpers for the matrix-multiply operand feeder.
//  state_t   : feeder FSM states (IDLE, LOAD_W, LOAD_X, FEED, DONE)
//  cnt_width : width of element/step counters, enough to hold N*N without wrapping
//  lane_lo   : low bit index of a DW-wide lane inside a packed lane vector
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    FEED,
    DONE
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n * n + 1);
  endfunction

  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/mm_skew_line.sv
// Module: mm_skew_line
// Per-lane delay line of depth D used to skew operands into a systolic array.
// Contents are zeroed on reset and on clear so no stale operand leaks out.
// Ports:
//  clk    in  1   clock
//  rst_n  in  1   asynchronous active-low reset
//  clear  in  1   synchronous flush to zero
//  d      in  DW  lane input
//  q      out DW  lane input delayed by D cycles (D = 0 is a straight wire)
import mm_pkg::*;

module mm_skew_line #(
  parameter int DW = 4,
  parameter int D  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  if (D == 0) begin : g_pass
    // Lane 0 has no skew; the clock/reset pins are intentionally unused here.
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, clear};
    assign q = d;
  end else begin : g_pipe
    logic [DW-1:0] pipe [D];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < D; s++) pipe[s] <= '0;
      end else if (clear) begin
        for (int s = 0; s < D; s++) pipe[s] <= '0;
      end else begin
        pipe[0] <= d;
        for (int s = 1; s < D; s++) pipe[s] <= pipe[s-1];
      end
    end

    assign q = pipe[D-1];
  end

endmodule

// File: rtl/mm_operand_feeder.sv
// Module: mm_operand_feeder
// Operand buffer/sequencer for an N x N MAC array. Loads W (M x K) then X (K x P)
// row-major over a valid/ready stream, then streams column k of W and row k of X
// for k = 0..K-1, with per-MAC enable/clear and a completion flag.
// Optional feature macro: FEEDER_SKEW_EN (systolic skew: w lane i and x lane j are
// delayed i and j cycles, FEED lasts K + 2*(N-1) cycles). Undefined: all lanes aligned,
// FEED lasts K cycles.
// Ports:
//  clk, rst_n           clock, asynchronous active-low reset
//  clear                synchronous abort to IDLE, highest priority
//  start                latches row_w/col_w/col_x (M/K/P) in IDLE or DONE
//  in_valid/in_ready    element stream handshake, in_data carries the element
//  w_out, x_out         N lanes of DW bits each, lane 0 in the low bits
//  feed_vld             high during every FEED cycle
//  mac_en, mac_clr      per-MAC enable (bit i*N+j) and its complement
//  done, cfg_err        result-ready level, illegal-dimension pulse
import mm_pkg::*;

module mm_operand_feeder #(
  parameter int DW   = 4,
  parameter int N    = 3,
  parameter int DIMW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            start,
  input  logic [DIMW-1:0] row_w,
  input  logic [DIMW-1:0] col_w,
  input  logic [DIMW-1:0] col_x,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic [N*DW-1:0] w_out,
  output logic [N*DW-1:0] x_out,
  output logic            feed_vld,
  output logic [N*N-1:0]  mac_en,
  output logic [N*N-1:0]  mac_clr,
  output logic            done,
  output logic            cfg_err
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0]   ONE = CW'(1);
  localparam logic [DIMW-1:0] N_D = DIMW'(N);
`ifdef FEEDER_SKEW_EN
  localparam logic [CW-1:0] L_EXTRA = CW'(2 * (N - 1));
`else
  localparam logic [CW-1:0] L_EXTRA = '0;
`endif

  state_t            state;
  logic [DIMW-1:0]   m_r, k_r, p_r;
  logic [CW-1:0]     cnt, t;
  logic [DW-1:0]     w_mem  [N*N];
  logic [DW-1:0]     x_mem  [N*N];
  logic [DW-1:0]     x_view [N*N];
  logic [N*DW-1:0]   w_bc, x_bc, w_bc_nxt, x_bc_nxt;
  logic [N*N-1:0]    mask;
  logic [CW-1:0]     beats_w, beats_x, last_t, s_nxt;
  logic              start_ok, wr_w, wr_x;

  function automatic logic dim_ok(input logic [DIMW-1:0] v);
    return (v != '0) && (v <= N_D);
  endfunction

  assign start_ok = dim_ok(row_w) && dim_ok(col_w) && dim_ok(col_x);
  assign beats_w  = CW'(m_r) * CW'(k_r);
  assign beats_x  = CW'(k_r) * CW'(p_r);
  assign last_t   = CW'(k_r) + L_EXTRA - ONE;
  assign wr_w     = (state == LOAD_W) && in_valid && !clear;
  assign wr_x     = (state == LOAD_X) && in_valid && !clear;
  assign mac_clr  = ~mac_en;

  // Operand storage is linear: W(i,k) at i*K+k, X(k,j) at k*P+j. No reset needed.
  always_ff @(posedge clk) begin
    if (wr_w) w_mem[cnt] <= in_data;
    if (wr_x) x_mem[cnt] <= in_data;
  end

  // Step 0 is registered on the same edge that writes the last X element, which
  // may itself be needed (K = 1), so reads see the in-flight write.
  always_comb begin
    x_view = x_mem;
    if (wr_x) x_view[cnt] = in_data;
  end

  // Unskewed operands for the step that the output registers will hold next;
  // steps at or beyond K are zero so skew lines drain cleanly.
  always_comb begin
    s_nxt    = (state == FEED) ? t + ONE : '0;
    w_bc_nxt = '0;
    x_bc_nxt = '0;
    if (s_nxt < CW'(k_r)) begin
      for (int i = 0; i < N; i++) begin
        if (DIMW'(i) < m_r)
          w_bc_nxt[lane_lo(i, DW) +: DW] = w_mem[CW'(i) * CW'(k_r) + s_nxt];
        if (DIMW'(i) < p_r)
          x_bc_nxt[lane_lo(i, DW) +: DW] = x_view[s_nxt * CW'(p_r) + CW'(i)];
      end
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mask[i*N+j] = (DIMW'(i) < m_r) && (DIMW'(j) < p_r);
  end

  // Feeder FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      t        <= '0;
      m_r      <= '0;
      k_r      <= '0;
      p_r      <= '0;
      in_ready <= 1'b0;
      feed_vld <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      mac_en   <= '0;
      w_bc     <= '0;
      x_bc     <= '0;
    end else if (clear) begin
      state    <= IDLE;
      cnt      <= '0;
      t        <= '0;
      in_ready <= 1'b0;
      feed_vld <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      mac_en   <= '0;
      w_bc     <= '0;
      x_bc     <= '0;
    end else begin
      cfg_err <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (start_ok) begin
              m_r      <= row_w;
              k_r      <= col_w;
              p_r      <= col_x;
              cnt      <= '0;
              state    <= LOAD_W;
              in_ready <= 1'b1;
              done     <= 1'b0;
              mac_en   <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (in_valid) begin
            if (cnt == beats_w - ONE) begin
              cnt   <= '0;
              state <= LOAD_X;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        LOAD_X: begin
          if (in_valid) begin
            if (cnt == beats_x - ONE) begin
              cnt      <= '0;
              t        <= '0;
              state    <= FEED;
              in_ready <= 1'b0;
              feed_vld <= 1'b1;
              mac_en   <= mask;
              w_bc     <= w_bc_nxt;
              x_bc     <= x_bc_nxt;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        FEED: begin
          if (t == last_t) begin
            t        <= '0;
            state    <= DONE;
            feed_vld <= 1'b0;
            done     <= 1'b1;
            w_bc     <= '0;
            x_bc     <= '0;
          end else begin
            t    <= t + ONE;
            w_bc <= w_bc_nxt;
            x_bc <= x_bc_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FEEDER_SKEW_EN
  for (genvar g = 0; g < N; g++) begin : g_lane
    mm_skew_line #(.DW(DW), .D(g)) u_w_skew (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .d(w_bc[g*DW +: DW]), .q(w_out[g*DW +: DW])
    );
    mm_skew_line #(.DW(DW), .D(g)) u_x_skew (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .d(x_bc[g*DW +: DW]), .q(x_out[g*DW +: DW])
    );
  end
`else
  assign w_out = w_bc;
  assign x_out = x_bc;
`endif

endmodule

// File: tb/tb_mm_operand_feeder.sv
// Testbench: tb_mm_operand_feeder
// Randomised load streams checked every cycle against a matrix-level model
// of the feeder, plus literal expectations for hand-worked cases.
// Follows FEEDER_SKEW_EN the same way the design does.
module tb_mm_operand_feeder;

  localparam int DW   = 4;
  localparam int N    = 3;
  localparam int DIMW = 2;
`ifdef FEEDER_SKEW_EN
  localparam bit SKEW  = 1'b1;
  localparam int EXTRA = 2 * (N - 1);
`else
  localparam bit SKEW  = 1'b0;
  localparam int EXTRA = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            start = 1'b0;
  logic [DIMW-1:0] row_w = '0, col_w = '0, col_x = '0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_ready, feed_vld, done, cfg_err;
  logic [N*DW-1:0] w_out, x_out;
  logic [N*N-1:0]  mac_en, mac_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mm_operand_feeder #(.DW(DW), .N(N), .DIMW(DIMW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .row_w(row_w), .col_w(col_w), .col_x(col_x),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_out(w_out), .x_out(x_out), .feed_vld(feed_vld),
    .mac_en(mac_en), .mac_clr(mac_clr), .done(done), .cfg_err(cfg_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Matrix-level model: phase 0 idle, 1 loading W, 2 loading X, 3 feeding, 4 done.
  int ph, mcnt, mt, mM, mK, mP;
  int Wm [N][N];
  int Xm [N][N];
  bit e_cfg;

  function automatic int feed_len(input int k);
    return k + EXTRA;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; mcnt = 0; mt = 0; e_cfg = 0; mM = 0; mK = 0; mP = 0;
    end else begin
      e_cfg = 0;
      if (clear) begin
        ph = 0; mcnt = 0;
      end else begin
        case (ph)
          0, 4: if (start) begin
            if (int'(row_w) >= 1 && int'(row_w) <= N && int'(col_w) >= 1 && int'(col_w) <= N &&
                int'(col_x) >= 1 && int'(col_x) <= N) begin
              mM = int'(row_w); mK = int'(col_w); mP = int'(col_x);
              ph = 1; mcnt = 0;
            end else e_cfg = 1;
          end
          1: if (in_valid) begin
            Wm[mcnt / mK][mcnt % mK] = int'(in_data);
            mcnt++;
            if (mcnt == mM * mK) begin mcnt = 0; ph = 2; end
          end
          2: if (in_valid) begin
            Xm[mcnt / mP][mcnt % mP] = int'(in_data);
            mcnt++;
            if (mcnt == mK * mP) begin mcnt = 0; ph = 3; mt = 0; end
          end
          3: if (mt == feed_len(mK) - 1) ph = 4; else mt++;
          default: ;
        endcase
      end
    end
  end

  // Single compare process: every cycle out of reset, all outputs vs model.
  always @(negedge clk) begin : cmp
    logic [N*DW-1:0] ew, ex;
    logic [N*N-1:0]  em, ec;
    int k;
    if (rst_n) begin
      ew = '0; ex = '0; em = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          em[i*N+j] = (ph == 3 || ph == 4) && (i < mM) && (j < mP);
      ec = ~em;
      if (ph == 3) begin
        for (int l = 0; l < N; l++) begin
          k = mt - (SKEW ? l : 0);
          if (l < mM && k >= 0 && k < mK) ew[l*DW +: DW] = DW'(Wm[l][k]);
          if (l < mP && k >= 0 && k < mK) ex[l*DW +: DW] = DW'(Xm[k][l]);
        end
      end
      checkOutput("in_ready", in_ready, (ph == 1 || ph == 2));
      checkOutput("feed_vld", feed_vld, (ph == 3));
      checkOutput("done", done, (ph == 4));
      checkOutput("cfg_err", cfg_err, e_cfg);
      checkOutput("mac_en", mac_en, em);
      checkOutput("mac_clr", mac_clr, ec);
      checkOutput("w_out", w_out, ew);
      checkOutput("x_out", x_out, ex);
    end
  end

  // Observation of the DUT for the literal pins below.
  int acc_beats, feed_cnt;
  bit prev_feed, prev_done, done_after_feed;
  logic [N*DW-1:0] feed_w [16];
  logic [N*DW-1:0] feed_x [16];

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_beats++;
      if (feed_vld) begin
        if (feed_cnt < 16) begin
          feed_w[feed_cnt] = w_out;
          feed_x[feed_cnt] = x_out;
        end
        feed_cnt++;
      end
      if (done && !prev_done) done_after_feed = prev_feed;
      prev_feed = feed_vld;
      prev_done = done;
    end
  end

  logic [DW-1:0] stim_q [$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearMon();
    acc_beats = 0; feed_cnt = 0; done_after_feed = 0;
  endtask

  task automatic applyStimulus(input int m, input int k, input int p, input int gap_pct);
    row_w = DIMW'(m); col_w = DIMW'(k); col_x = DIMW'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < stim_q.size(); b++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0; in_data = DW'($urandom); tick();
      end
      in_valid = 1'b1; in_data = stim_q[b]; tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int c;
    c = 0;
    while (!done && c < 200) begin tick(); c++; end
    if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic fillRandom(input int n);
    stim_q.delete();
    for (int b = 0; b < n; b++) stim_q.push_back(DW'($urandom));
  endtask

  initial begin
    int m, k, p;
    $display("[TB] feeder bench, skew=%0d", SKEW);

    // Reset state
    tick(); tick();
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_mac_clr", mac_clr, 9'h1FF);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_w_out", w_out, 12'h000);
    rst_n = 1'b1;
    tick();

    // 3x3 * 3x3, W = 1..9, X = 9..1
    stim_q.delete();
    for (int b = 0; b < 9; b++) stim_q.push_back(DW'(b + 1));
    for (int b = 0; b < 9; b++) stim_q.push_back(DW'(9 - b));
    clearMon();
    applyStimulus(3, 3, 3, 0);
    waitDone();
    tick();
    checkOutput("feed_len_3x3", feed_cnt, 3 + EXTRA);
    checkOutput("done_after_feed_3x3", done_after_feed, 1'b1);
    checkOutput("mac_en_3x3", mac_en, 9'h1FF);
`ifdef FEEDER_SKEW_EN
    checkOutput("skew_w_t0", feed_w[0], 12'h001);
    checkOutput("skew_x_t0", feed_x[0], 12'h009);
    checkOutput("skew_w2_t1", feed_w[1][11:8], 4'd0);
    checkOutput("skew_w2_t2", feed_w[2][11:8], 4'd7);
    checkOutput("skew_x1_t3", feed_x[3][7:4], 4'd2);
    checkOutput("skew_x1_t4", feed_x[4][7:4], 4'd0);
`else
    checkOutput("w_step0", feed_w[0], 12'h741);
    checkOutput("x_step0", feed_x[0], 12'h789);
    checkOutput("w_step2", feed_w[2], 12'h963);
    checkOutput("x_step2", feed_x[2], 12'h123);
`endif

    // 2x3 * 3x1 with gaps
    fillRandom(6 + 3);
    clearMon();
    applyStimulus(2, 3, 1, 30);
    waitDone();
    tick();
    checkOutput("mac_en_2x3x1", mac_en, 9'b000_001_001);
    checkOutput("feed_len_2x3x1", feed_cnt, 3 + EXTRA);
    for (int c = 0; c < feed_cnt && c < 16; c++) begin
      checkOutput("w_lane2_zero", feed_w[c][11:8], 4'd0);
      checkOutput("x_lane12_zero", feed_x[c][11:4], 8'd0);
    end

    // 1x1 * 1x1 with in_valid toggling
    clearMon();
    row_w = 2'd1; col_w = 2'd1; col_x = 2'd1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c % 2 == 0);
      in_data = DW'(c + 3);
      tick();
    end
    in_valid = 1'b0;
    waitDone();
    tick();
    checkOutput("beats_1x1", acc_beats, 2);
    checkOutput("feed_len_1x1", feed_cnt, 1 + EXTRA);
    checkOutput("done_after_feed_1x1", done_after_feed, 1'b1);

    // clear on beat 4 of LOAD_W, then a fresh load
    row_w = 2'd3; col_w = 2'd3; col_x = 2'd3;
    start = 1'b1; tick(); start = 1'b0;
    for (int b = 0; b < 3; b++) begin in_valid = 1'b1; in_data = DW'(b + 5); tick(); end
    in_valid = 1'b1; clear = 1'b1; tick();
    clear = 1'b0; in_valid = 1'b0;
    checkOutput("clr_in_ready", in_ready, 1'b0);
    checkOutput("clr_mac_clr", mac_clr, 9'h1FF);
    checkOutput("clr_done", done, 1'b0);
    fillRandom(18);
    clearMon();
    applyStimulus(3, 3, 3, 20);
    waitDone();
    tick();
    checkOutput("reload_w00", feed_w[0][3:0], stim_q[0]);
    checkOutput("reload_x00", feed_x[0][3:0], stim_q[9]);

    // Illegal dimensions from IDLE
    clear = 1'b1; tick(); clear = 1'b0;
    row_w = 2'd2; col_w = 2'd2; col_x = 2'd0;
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("cfg_err_pulse", cfg_err, 1'b1);
    checkOutput("cfg_in_ready", in_ready, 1'b0);
    tick();
    checkOutput("cfg_err_once", cfg_err, 1'b0);
    checkOutput("cfg_in_ready2", in_ready, 1'b0);
    row_w = 2'd0; col_x = 2'd1;
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("cfg_err_row0", cfg_err, 1'b1);

    // Random runs; a start during FEED must be ignored
    for (int r = 0; r < 8; r++) begin
      m = int'($urandom_range(1, N));
      k = int'($urandom_range(1, N));
      p = int'($urandom_range(1, N));
      fillRandom(m * k + k * p);
      clearMon();
      applyStimulus(m, k, p, 25);
      row_w = DIMW'($urandom); start = 1'b1; tick(); start = 1'b0;
      waitDone();
      tick();
      checkOutput("rand_feed_len", feed_cnt, k + EXTRA);
    end

    // Asynchronous reset mid-load
    fillRandom(18);
    row_w = 2'd3; col_w = 2'd3; col_x = 2'd3;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd1; tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_in_ready", in_ready, 1'b0);
    checkOutput("arst_mac_clr", mac_clr, 9'h1FF);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
